// File: rtl/seq_burst_gen.sv
// Serial burst generator: emits `bursts` runs of 1s, each run_len long and
// followed by gap_len 0s, then pulses done for one cycle.
module seq_burst_gen #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [CNT_W-1:0] bursts,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] burst_cnt
);

  // state | meaning
  // IDLE  | waiting for an acceptable start
  // RUN   | emitting the 1s of a burst
  // GAP   | emitting the 0s after a burst
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [LEN_W-1:0] run_q, run_n, gap_q, gap_n;
  logic [CNT_W-1:0] bursts_q, bursts_n;
  logic [CNT_W-1:0] burst_cnt_n, burst_inc;
  logic             out_n, busy_n, done_n, burst_end;

  assign burst_inc = burst_cnt + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      run_q     <= '0;
      gap_q     <= '0;
      bursts_q  <= '0;
      burst_cnt <= '0;
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      run_q     <= run_n;
      gap_q     <= gap_n;
      bursts_q  <= bursts_n;
      burst_cnt <= burst_cnt_n;
      out       <= out_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // cnt holds the cycles remaining in the current phase after this one
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    run_n       = run_q;
    gap_n       = gap_q;
    bursts_n    = bursts_q;
    burst_cnt_n = burst_cnt;
    out_n       = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    burst_end   = 1'b0;
    case (state)
      IDLE: begin
        if (start && run_len != '0 && bursts != '0) begin
          run_n       = run_len;
          gap_n       = gap_len;
          bursts_n    = bursts;
          burst_cnt_n = '0;
          cnt_n       = run_len - 1'b1;
          state_n     = RUN;
          out_n       = 1'b1;
          busy_n      = 1'b1;
        end
      end
      RUN: begin
        busy_n = 1'b1;
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
          out_n = 1'b1;
        end else if (gap_q != '0) begin
          cnt_n   = gap_q - 1'b1;
          state_n = GAP;
        end else begin
          burst_end = 1'b1;
        end
      end
      GAP: begin
        busy_n = 1'b1;
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else           burst_end = 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // a zero gap chains straight into the next run, merging bursts
    if (burst_end) begin
      burst_cnt_n = burst_inc;
      if (burst_inc == bursts_q) begin
        state_n = DONE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        out_n   = 1'b0;
      end else begin
        state_n = RUN;
        cnt_n   = run_q - 1'b1;
        out_n   = 1'b1;
        busy_n  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_burst_gen.sv
// Directed self-checking bench for seq_burst_gen; samples on the falling edge
// and compares {out,busy,done,burst_cnt} against hand-derived sequences.
module tb_seq_burst_gen;
  localparam int LEN_W = 4;
  localparam int CNT_W = 4;

  logic             clock, reset, start;
  logic [LEN_W-1:0] run_len, gap_len;
  logic [CNT_W-1:0] bursts;
  logic             out, busy, done;
  logic [CNT_W-1:0] burst_cnt;

  int checks = 0;
  int failures = 0;

  seq_burst_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .run_len(run_len),
    .gap_len(gap_len), .bursts(bursts), .out(out), .busy(busy),
    .done(done), .burst_cnt(burst_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // expected vector layout: {out, busy, done, burst_cnt}
  function automatic logic [6:0] pk(input logic o, input logic b, input logic d, input int c);
    return {o, b, d, 4'(c)};
  endfunction

  task automatic load(input int r, input int g, input int b);
    run_len = 4'(r); gap_len = 4'(g); bursts = 4'(b);
  endtask

  task automatic test_reset;
    logic [6:0] obs;
    start = 1'b0; load(0, 0, 0);
    reset = 1'b0;
    #1;
    obs = {out, busy, done, burst_cnt};
    checks++;
    if (obs !== 7'b0) begin
      failures++;
      $display("FAIL reset_state observed=%b expected=%b", obs, 7'b0);
    end
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single;
    logic [6:0] exp_q[$];
    logic [6:0] obs;
    exp_q = '{pk(1,1,0,0), pk(1,1,0,0), pk(1,1,0,0), pk(0,1,0,0), pk(0,1,0,0),
              pk(0,0,1,1), pk(0,0,0,1)};
    @(negedge clock);
    load(3, 2, 1); start = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clock);
      start = 1'b0;
      obs = {out, busy, done, burst_cnt};
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL single_burst cycle=%0d observed=%b expected=%b", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_multi;
    logic [6:0] exp_q[$];
    logic [6:0] obs;
    exp_q = '{pk(1,1,0,0), pk(0,1,0,0), pk(1,1,0,1), pk(0,1,0,1), pk(1,1,0,2),
              pk(0,1,0,2), pk(0,0,1,3), pk(0,0,0,3)};
    load(1, 1, 3); start = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clock);
      start = 1'b0;
      obs = {out, busy, done, burst_cnt};
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL multi_burst cycle=%0d observed=%b expected=%b", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_merge;
    logic [6:0] exp_q[$];
    logic [6:0] obs;
    exp_q = '{pk(1,1,0,0), pk(1,1,0,0), pk(1,1,0,1), pk(1,1,0,1), pk(0,0,1,2),
              pk(0,0,0,2)};
    load(2, 0, 2); start = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clock);
      start = 1'b0;
      obs = {out, busy, done, burst_cnt};
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL merged_gap0 cycle=%0d observed=%b expected=%b", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_ignore;
    logic [6:0] obs;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) load(0, 2, 5);
      else        load(3, 2, 0);
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        obs = {out, busy, done, burst_cnt};
        checks++;
        if (obs !== pk(0,0,0,2)) begin
          failures++;
          $display("FAIL ignored_start case=%0d cycle=%0d observed=%b expected=%b",
                   k, i, obs, pk(0,0,0,2));
        end
      end
      start = 1'b0;
    end
  endtask

  task automatic test_abort;
    logic [6:0] exp_q[$];
    logic [6:0] obs;
    load(4, 4, 2); start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      start = 1'b0;
      obs = {out, busy, done, burst_cnt};
      checks++;
      if (obs !== pk(1,1,0,0)) begin
        failures++;
        $display("FAIL abort_prefix cycle=%0d observed=%b expected=%b", i, obs, pk(1,1,0,0));
      end
    end
    reset = 1'b0;
    #1;
    obs = {out, busy, done, burst_cnt};
    checks++;
    if (obs !== 7'b0) begin
      failures++;
      $display("FAIL abort_async observed=%b expected=%b", obs, 7'b0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      obs = {out, busy, done, burst_cnt};
      checks++;
      if (obs !== 7'b0) begin
        failures++;
        $display("FAIL abort_held cycle=%0d observed=%b expected=%b", i, obs, 7'b0);
      end
    end
    reset = 1'b1;
    load(1, 0, 1); start = 1'b1;
    exp_q = '{pk(1,1,0,0), pk(0,0,1,1), pk(0,0,0,1)};
    foreach (exp_q[i]) begin
      @(negedge clock);
      start = 1'b0;
      obs = {out, busy, done, burst_cnt};
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL post_reset_start cycle=%0d observed=%b expected=%b", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_hold_start;
    logic [6:0] exp_q[$];
    logic [6:0] obs;
    // after DONE the still-high start is only taken from IDLE, with the new fields
    exp_q = '{pk(1,1,0,0), pk(1,1,0,0), pk(1,1,0,0), pk(0,1,0,0), pk(0,0,1,1),
              pk(0,0,0,1), pk(1,1,0,0)};
    load(3, 1, 1); start = 1'b1;
    foreach (exp_q[i]) begin
      @(negedge clock);
      if (i == 0) load(7, 5, 4);
      obs = {out, busy, done, burst_cnt};
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL held_start cycle=%0d observed=%b expected=%b", i, obs, exp_q[i]);
      end
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_merge();
    test_ignore();
    test_abort();
    test_hold_start();
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_burst_gen.md
SEQ_BURST_GEN -- requirements
Module: seq_burst_gen

Interface
REQ-001 Parameter LEN_W, default 4, SHALL set the width of the run-length and gap-length fields.
REQ-002 Parameter CNT_W, default 4, SHALL set the width of the burst-count fields.
REQ-003 Port clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port start  input  1  SHALL request a transmission; sampled only in IDLE.
REQ-006 Port run_len  input  LEN_W  SHALL give the number of consecutive 1 bits per burst.
REQ-007 Port gap_len  input  LEN_W  SHALL give the number of 0 bits after each burst.
REQ-008 Port bursts  input  CNT_W  SHALL give the number of bursts to emit.
REQ-009 Port out  output  1  SHALL be the registered serial bit stream.
REQ-010 Port busy  output  1  SHALL be high while a transmission is in progress.
REQ-011 Port done  output  1  SHALL pulse high for one cycle at the end of a transmission.
REQ-012 Port burst_cnt  output  CNT_W  SHALL report the number of bursts fully emitted (run plus gap) in the current or last transmission.

Function
REQ-013 FSM states SHALL be IDLE, RUN, GAP, DONE; all outputs registered.
REQ-014 IDLE: out=0, busy=0; edge with start=1, run_len!=0, bursts!=0 SHALL capture run_len, gap_len, bursts, clear burst_cnt, and enter RUN.
REQ-015 IDLE, start=1 with run_len=0 or bursts=0: request SHALL be ignored; stay IDLE, no done pulse.
REQ-016 Latency: out SHALL be 1 in the first cycle after the accepting edge; busy SHALL rise on the same edge.
REQ-017 RUN: out=1 for exactly captured run_len cycles, then GAP if gap_len!=0, otherwise burst end.
REQ-018 GAP: out=0 for exactly captured gap_len cycles, then burst end.
REQ-019 Burst end: burst_cnt SHALL increment; if burst_cnt reaches captured bursts, enter DONE, else re-enter RUN.
REQ-020 gap_len=0: consecutive bursts SHALL merge into one unbroken run of 1s (run_len*bursts cycles); no idle bit inserted.
REQ-021 DONE: lasts one cycle; done=1, busy=0, out=0; next edge returns to IDLE.
REQ-022 start in RUN, GAP or DONE SHALL be ignored; no queuing.
REQ-023 Changes to run_len, gap_len, bursts after capture SHALL NOT affect the transmission in progress.
REQ-024 Internal counters SHALL be sized to count max field values (2^LEN_W-1, 2^CNT_W-1) without wrap.
REQ-025 burst_cnt SHALL hold its final value in DONE and IDLE until the next accepted start.

Reset
REQ-026 reset low SHALL immediately (asynchronously) force state IDLE, out=0, busy=0, done=0, burst_cnt=0, counters cleared.
REQ-027 Reset asserted mid-transmission SHALL abort without a done pulse.
REQ-028 First rising edge with reset high SHALL be able to accept start.

Verification
REQ-029 run_len=3, gap_len=2, bursts=1, start one cycle -> out over following cycles 1,1,1,0,0; done pulses in the next cycle; burst_cnt=1; busy high 5 cycles.
REQ-030 run_len=1, gap_len=1, bursts=3 -> out 1,0,1,0,1,0; then done one cycle; burst_cnt steps 1,2,3.
REQ-031 run_len=2, gap_len=0, bursts=2 -> out 1,1,1,1 contiguous; done next cycle; burst_cnt=2.
REQ-032 start with run_len=0 (bursts=5) and separately bursts=0 (run_len=3) -> busy, out, done stay 0; burst_cnt unchanged.
REQ-033 run_len=4, gap_len=4, bursts=2; reset low after 3rd out=1 cycle -> out, busy, burst_cnt go 0 immediately, no done; start one edge after release with run_len=1, gap_len=0, bursts=1 -> out 1 single cycle, then done.
REQ-034 start held high throughout and inputs changed mid-run (run_len=3, gap_len=1, bursts=1 at capture) -> exactly 1,1,1,0 then done; new transmission accepted only from IDLE after DONE.
